// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of the single-port data RAM.
// Master 0 is the core load/store port and master 1 is the UART loader/debug port.
// At most one access is issued per cycle. The slave answers one cycle later, and that
// response is routed back to the master that issued the access.
//
// Configuration macro: ARB_FIXED_PRIO_EN
//   undefined (default): round-robin arbitration with a bounded lock
//   defined            : master 0 always wins a contested cycle, and m*_lock is ignored
//
// Ports
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   m{0,1}_req/we/lock          per-master request, write select and lock hint
//   m{0,1}_addr/wdata           per-master address and write data
//   m{0,1}_gnt                  access issued this cycle (combinational)
//   m{0,1}_rvalid/rdata         response one cycle after grant (rdata holds between responses)
//   s_we/s_re/s_addr/s_wdata    slave strobes and payload (combinational from the winner)
//   s_rdata                     slave read data, valid the cycle after s_re
module data_bus_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_we,
    output logic                  s_re,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    logic grant_c;
    logic win1_c;
    logic win_we_c;

    // No access is issued while reset is asserted.
    assign grant_c = rst_n & (m0_req | m1_req);

`ifdef ARB_FIXED_PRIO_EN
    // Master 0 wins every contested cycle.
    logic unused_lock_c;
    assign unused_lock_c = m0_lock ^ m1_lock;
    assign win1_c        = m1_req & ~m0_req;
`else
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    logic             last_winner;
    logic             win_lock;
    logic [CNT_W-1:0] lock_cnt;
    logic             cur_lock_c;
    logic             other_req_c;

    // Winner selection: a locked previous winner keeps the bus until its budget runs out.
    always_comb begin
        win1_c = m1_req;
        if (m0_req && m1_req) begin
            if (win_lock && (lock_cnt < CNT_W'(MAX_LOCK))) begin
                win1_c = last_winner;
            end else begin
                win1_c = ~last_winner;
            end
        end
    end

    assign cur_lock_c  = win1_c ? m1_lock : m0_lock;
    assign other_req_c = win1_c ? m0_req  : m1_req;

    // Lock budget: counts contested, locked repeat grants and saturates at MAX_LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
            win_lock    <= 1'b0;
            lock_cnt    <= '0;
        end else if (grant_c) begin
            last_winner <= win1_c;
            win_lock    <= cur_lock_c;
            if ((win1_c == last_winner) && other_req_c && cur_lock_c) begin
                if (lock_cnt < CNT_W'(MAX_LOCK)) begin
                    lock_cnt <= lock_cnt + CNT_W'(1);
                end
            end else begin
                lock_cnt <= '0;
            end
        end else begin
            lock_cnt <= '0;
        end
    end
`endif

    assign win_we_c = win1_c ? m1_we : m0_we;
    assign m0_gnt   = grant_c & ~win1_c;
    assign m1_gnt   = grant_c &  win1_c;
    assign s_we     = grant_c &  win_we_c;
    assign s_re     = grant_c & ~win_we_c;
    assign s_addr   = grant_c ? (win1_c ? m1_addr  : m0_addr)  : '0;
    assign s_wdata  = grant_c ? (win1_c ? m1_wdata : m0_wdata) : '0;

    logic                  rsp_we;
    logic [DATA_WIDTH-1:0] hold0;
    logic [DATA_WIDTH-1:0] hold1;

    // Owner tag for the access in flight; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            rsp_we    <= win_we_c;
        end
    end

    // The slave data arrives during the response cycle, so it is passed through directly
    // and latched for the cycles that follow.
    always_comb begin
        m0_rdata = hold0;
        m1_rdata = hold1;
        if (m0_rvalid) begin
            m0_rdata = rsp_we ? '0 : s_rdata;
        end
        if (m1_rvalid) begin
            m1_rdata = rsp_we ? '0 : s_rdata;
        end
    end

    // Each master's last delivered data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (m0_rvalid) begin
                hold0 <= m0_rdata;
            end
            if (m1_rvalid) begin
                hold1 <= m1_rdata;
            end
        end
    end

endmodule
